apb_master_multi: RTL and testbench
===================================

Name: apb_master_multi

Overview:
- Parametrised APB master bridge that replaces the fixed two-slave master in the APB subsystem.
- Accepts single read/write requests on a valid/ready request port and drives NUM_SLAVES APB completers through one-hot PSEL.
- Adds the following behaviour, generalised in width and slave count:
  - address-region decode with a decode-error response
  - PSTRB byte strobes
  - PSLVERR propagation
  - a programmable PREADY wait-state timeout

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width (multiple of 8)
NUM_SLAVES, 4, number of APB completers (1..16)
REGION_BITS, 12, log2 of bytes per slave region; slave index = req_addr >> REGION_BITS
TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  bridge accepts request (IDLE only)
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
req_strb  in  DATA_W/8  write byte enables
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  slave error, decode error or timeout
PSEL  out  NUM_SLAVES  one-hot select
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes (forced 0 on reads)
PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data, slave k at bits [k*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async, while PRESET=1):
  - state=IDLE
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - req_ready=0 while PRESET=1; =1 in IDLE otherwise.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Handshake at edge T when req_valid && req_ready.
  - On handshake, register addr/wdata/strb/write into PADDR/PWDATA/PSTRB/PWRITE.
  - idx = req_addr >> REGION_BITS.
  - idx < NUM_SLAVES -> SETUP.
  - Otherwise -> RESP with err=1, rdata=0; no PSEL asserted.
- SETUP (cycle after T):
  - PSEL[idx]=1, PENABLE=0.
  - Unconditionally -> ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1, address/control/data held stable.
  - Wait counter starts at 1 in the first ACCESS cycle.
  - PREADY[idx]=1: capture rdata=PRDATA slice idx (reads only; 0 for writes) and err=PSLVERR[idx]; -> RESP.
  - TIMEOUT!=0 and counter==TIMEOUT with PREADY[idx]=0: -> RESP with err=1, rdata=0.
  - Otherwise the counter increments.
  - PREADY/PSLVERR of unselected slaves are ignored.
- RESP:
  - PSEL=0, PENABLE=0.
  - rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err.
  - -> IDLE.
  - rsp_rdata/rsp_err hold their value until the next response; rsp_valid returns to 0.
- Latency (zero-wait slave):
  - Handshake edge T; SETUP cycle T+1; ACCESS T+2; rsp_valid high T+3.
  - Each wait state adds 1 cycle.
  - Decode error: rsp_valid at T+1.
- Back-to-back throughput: one transfer per 4 cycles minimum; req_ready=0 in SETUP/ACCESS/RESP; requests there are not accepted and must be held by the requester.
- Timeout with TIMEOUT=N:
  - PENABLE is high for exactly N cycles, then drops.
  - A PREADY arriving in the cycle after abort is ignored.
- PSTRB is driven as req_strb for writes and all-zero for reads.
- Reset mid-transfer: PSEL/PENABLE drop immediately (async); no rsp_valid is produced for the aborted transfer.
- No outstanding-transaction queue; the bridge is strictly single-transfer.

Test Plan:
- Write 0xDEADBEEF, strb 0xF, addr 0x0000_1010 (slave 1), PREADY[1] tied 1 -> PSEL=0b0010 at T+1, PENABLE at T+2, PADDR=0x1010, PSTRB=0xF, rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
- Read addr 0x0000_3004 (slave 3), PRDATA slice 3=0x12345678, PREADY[3] delayed 2 cycles -> PENABLE high 3 cycles, rsp_valid at T+5, rsp_rdata=0x12345678, PSTRB=0.
- Read addr 0x0000_5000 with NUM_SLAVES=4 -> PSEL stays 0, rsp_valid at T+1, rsp_err=1, rsp_rdata=0.
- Write to slave 2 with PREADY[2]=1 and PSLVERR[2]=1 -> rsp_err=1; the next read to slave 0 with PSLVERR=0 -> rsp_err=0.
- TIMEOUT=16, slave 0 never asserts PREADY -> PENABLE high exactly 16 cycles, then rsp_valid with rsp_err=1; req_ready returns 1 the cycle after.
- Assert PRESET during ACCESS of a slave-1 read -> PSEL/PENABLE 0 immediately, no rsp_valid; after release, a 40-entry write loop to slaves 0..3 completes with all rsp_err=0.

Source files
------------

// File: rtl/apb_master_multi.sv
// APB master bridge: one valid/ready request in, one APB transfer out to one of
// NUM_SLAVES completers selected by address region. Reports slave errors,
// decode errors and PREADY timeouts on a one-cycle response pulse.
module apb_master_multi #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int REGION_BITS = 12,
    parameter int TIMEOUT     = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_strb,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                pwrite_q, pwrite_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   req_region;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;

    assign req_region  = req_addr >> REGION_BITS;
    assign sel_ready   = PREADY[idx_q];
    assign sel_err     = PSLVERR[idx_q];
    assign sel_rdata   = PRDATA[idx_q*DATA_W +: DATA_W];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    // Decoded from state so PSEL/PENABLE fall as soon as PRESET clears the state.
    assign req_ready = (state_q == ST_IDLE) && !PRESET;
    assign rsp_valid = (state_q == ST_RESP);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PSEL      = ((state_q == ST_SETUP) || (state_q == ST_ACCESS))
                       ? (NUM_SLAVES'(1) << idx_q) : '0;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PWRITE    = pwrite_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // State, captured request and held response registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state: accept and decode in IDLE, wait for PREADY or timeout in ACCESS.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    pstrb_d  = req_write ? req_strb : '0;
                    pwrite_d = req_write;
                    idx_d    = req_region[IDX_W-1:0];
                    if (req_region < ADDR_W'(NUM_SLAVES)) begin
                        state_d = ST_SETUP;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_W'(1);
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    rdata_d = pwrite_q ? '0 : sel_rdata;
                    err_d   = sel_err;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_multi.sv
// Scoreboard bench for apb_master_multi: the driver pushes the expected response
// of each accepted request; a monitor pops and compares on every rsp_valid and
// checks APB signals during SETUP/ACCESS against the request in flight.
module tb_apb_master_multi;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int RB = 12;
    localparam int TO = 16;
    localparam int SW = DW / 8;
    localparam int NEVER = 1000;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [SW-1:0]     req_strb;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NS-1:0]     PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic [NS*DW-1:0]  PRDATA;
    logic [NS-1:0]     PREADY;
    logic [NS-1:0]     PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_master_multi #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .REGION_BITS(RB), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    // Slave models: configured wait states / error / read data per slave;
    // unselected slaves drive random noise on PREADY/PSLVERR.
    int          wait_cfg [NS];
    logic        err_cfg  [NS];
    logic [DW-1:0] rdata_cfg [NS];
    logic [NS-1:0] noise_rdy = '0;
    logic [NS-1:0] noise_err = '0;
    int          acc_cnt;
    int          cyc = 0;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            PREADY[k]  = (PSEL[k] && PENABLE) ? (acc_cnt >= wait_cfg[k]) : noise_rdy[k];
            PSLVERR[k] = PSEL[k] ? err_cfg[k] : noise_err[k];
            PRDATA[k*DW +: DW] = rdata_cfg[k];
        end
    end

    // Counts ACCESS cycles already elapsed for the selected slave.
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET)       acc_cnt <= 0;
        else if (PENABLE) acc_cnt <= acc_cnt + 1;
        else              acc_cnt <= 0;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        noise_rdy <= NS'($urandom);
        noise_err <= NS'($urandom);
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
        int            pen;
    } exp_t;

    exp_t exp_q[$];

    logic [NS-1:0] if_sel   = '0;
    logic [AW-1:0] if_addr  = '0;
    logic [DW-1:0] if_wdata = '0;
    logic [SW-1:0] if_strb  = '0;
    logic          if_write = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: outcome from address region, slave wait/err config and timeout.
    // cyc is the offset of the response cycle from the handshake edge.
    function automatic exp_t model(input logic w, input logic [AW-1:0] a, input int wt,
                                   input logic er, input logic [DW-1:0] rd);
        exp_t e;
        int idx;
        idx = int'(a >> RB);
        if (idx >= NS) begin
            e.rdata = '0; e.err = 1'b1; e.cyc = 0; e.pen = 0;
        end else if (TO != 0 && wt >= TO) begin
            e.rdata = '0; e.err = 1'b1; e.cyc = 1 + TO; e.pen = TO;
        end else begin
            e.rdata = w ? '0 : rd; e.err = er; e.cyc = 2 + wt; e.pen = wt + 1;
        end
        return e;
    endfunction

    // Monitor / scoreboard.
    int   pen_cnt  = 0;
    logic prev_rsp = 1'b0;
    exp_t got;

    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (PSEL != '0) check("psel", 64'(PSEL), 64'(if_sel));
            if (PENABLE) begin
                pen_cnt++;
                check("paddr",  64'(PADDR),  64'(if_addr));
                check("pwrite", 64'(PWRITE), 64'(if_write));
                check("pwdata", 64'(PWDATA), 64'(if_wdata));
                check("pstrb",  64'(PSTRB),  64'(if_write ? if_strb : '0));
            end
            if (prev_rsp) check("ready_after_rsp", 64'(req_ready), 64'(1));
            if (rsp_valid) begin
                check("ready_in_resp", 64'(req_ready), 64'(0));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: rsp_valid with no outstanding request (t=%0t)", $time);
                end else begin
                    got = exp_q.pop_front();
                    check("rsp_rdata",    64'(rsp_rdata), 64'(got.rdata));
                    check("rsp_err",      64'(rsp_err),   64'(got.err));
                    check("rsp_cycle",    64'(cyc),       64'(got.cyc));
                    check("penable_cycles", 64'(pen_cnt), 64'(got.pen));
                end
                pen_cnt = 0;
            end
            prev_rsp = rsp_valid;
        end else begin
            pen_cnt  = 0;
            prev_rsp = 1'b0;
        end
    end

    // Issue one request; while the bridge is busy, junk is presented to show it is not taken.
    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int wt, input logic er,
                          input logic [DW-1:0] rd);
        int   n;
        int   idx;
        exp_t e;
        n = 0;
        @(negedge PCLK);
        while (!req_ready && n < 200) begin
            req_valid = 1'b1;
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_strb  = SW'($urandom);
            @(negedge PCLK);
            n++;
        end
        if (n >= 200) begin
            check("req_ready_timeout", 64'(req_ready), 64'(1));
            req_valid = 1'b0;
            return;
        end
        idx = int'(a >> RB);
        if (idx < NS) begin
            wait_cfg[idx]  = wt;
            err_cfg[idx]   = er;
            rdata_cfg[idx] = rd;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        if_sel   = (idx < NS) ? (NS'(1) << idx) : '0;
        if_addr  = a;
        if_wdata = d;
        if_strb  = s;
        if_write = w;
        e = model(w, a, wt, er, rd);
        e.cyc = e.cyc + cyc;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wt;
        int r;
        logic [AW-1:0] a;
        for (int k = 0; k < NS; k++) begin
            wait_cfg[k] = 0; err_cfg[k] = 1'b0; rdata_cfg[k] = $urandom;
        end
        PRESET = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
        #12;
        check("rst_psel",      64'(PSEL),      64'(0));
        check("rst_penable",   64'(PENABLE),   64'(0));
        check("rst_pwrite",    64'(PWRITE),    64'(0));
        check("rst_paddr",     64'(PADDR),     64'(0));
        check("rst_pwdata",    64'(PWDATA),    64'(0));
        check("rst_pstrb",     64'(PSTRB),     64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_err",   64'(rsp_err),   64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("idle_req_ready", 64'(req_ready), 64'(1));

        // Directed cases.
        do_req(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
        do_req(1'b0, 32'h0000_3004, 32'h0, 4'hA, 2, 1'b0, 32'h1234_5678);
        drain();
        repeat (2) @(negedge PCLK);
        check("rdata_hold", 64'(rsp_rdata), 64'(32'h1234_5678));
        do_req(1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 1'b0, 32'hFFFF_FFFF);
        do_req(1'b1, 32'h0000_2000, 32'h0BAD_F00D, 4'h3, 0, 1'b1, 32'h0);
        do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, 1, 1'b0, 32'hCAFE_0001);
        do_req(1'b0, 32'h0000_0000, 32'h0, 4'h0, NEVER, 1'b0, 32'h5555_AAAA);
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0F0F_0F0F);
        do_req(1'b1, 32'h0000_3100, 32'h1111_2222, 4'h5, TO, 1'b0, 32'h0);
        drain();

        // Reset in the middle of an ACCESS phase.
        do_req(1'b0, 32'h0000_1020, 32'h0, 4'h0, 8, 1'b0, 32'h7777_8888);
        n = 0;
        while (!PENABLE && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        check("reached_access", 64'(PENABLE), 64'(1));
        @(negedge PCLK);
        #2;
        PRESET = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_psel",      64'(PSEL),      64'(0));
        check("midrst_penable",   64'(PENABLE),   64'(0));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);

        // 40 writes across all slaves with no errors.
        for (int i = 0; i < 40; i++) begin
            a = (AW'(i % NS) << RB) | AW'($urandom_range(0, 1023) * 4);
            do_req(1'b1, a, $urandom, SW'($urandom), $urandom_range(0, 3), 1'b0, $urandom);
        end
        drain();

        // Random mix including decode errors, slave errors and timeouts.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       wt = $urandom_range(0, 3);
            else if (r == 7) wt = TO - 1;
            else if (r == 8) wt = TO;
            else             wt = NEVER;
            a = (AW'($urandom_range(0, NS + 1)) << RB) | AW'($urandom_range(0, 4095));
            do_req(1'($urandom), a, $urandom, SW'($urandom), wt, 1'($urandom), $urandom);
        end
        drain();
        repeat (3) @(negedge PCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
